type_rule_cfg_ctrl: RTL and testbench
=====================================

// Module: type_rule_cfg_ctrl
// PURPOSE
// - Configuration sequencer for the parser type-lookup rule table.
// - Takes a 32-bit host config beat stream (valid/ready) and assembles rule records.
// - Drives the table's per-rule one-hot write enables plus the rule payload.
// - Supports per-rule write, per-rule invalidate and clear-all sweep, and keeps a shadow valid bitmap.
// PARAMETERS
// RULE_NUM          8   number of rule entries in the type-lookup table
// TYPE_NUM          4   type fields per rule
// TYPE_WIDTH        16  bits per type field
// KEY_FILED_NUM     8   key-offset fields per rule
// KEY_OFFSET_WIDTH  6   bits per key offset
// CFG_WIDTH         32  host beat width
// PORTS
// i_clk               in   1                           clock
// i_rst               in   1                           asynchronous active-high reset
// i_cfg_valid         in   1                           host beat valid
// i_cfg_data          in   CFG_WIDTH                   host beat
// o_cfg_ready         out  1                           beat accepted when valid&ready
// o_rule_wren         out  RULE_NUM                    one-hot table write enable, 1-cycle pulse
// o_typeRule_valid    out  1                           rule valid bit to write
// o_typeRule_typeData out  TYPE_NUM*TYPE_WIDTH         type match data
// o_typeRule_typeMask out  TYPE_NUM*TYPE_WIDTH         type match mask
// o_typeRule_keyOffset out KEY_FILED_NUM*KEY_OFFSET_WIDTH key offsets
// o_rule_valid_map    out  RULE_NUM                    shadow of table valid bits
// o_busy              out  1                           op in progress (not IDLE)
// o_done              out  1                           1-cycle pulse, op committed
// o_err               out  1                           1-cycle pulse, bad opcode/index
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; o_cfg_ready 0 during reset, 1 on the first cycle after.
// - Header beat: [31:28] opcode (1=WRITE, 2=INVAL, 3=CLEAR_ALL); [15:0] rule index.
// - Payload: record {keyOffset, typeMask, typeData} packed LSB-first (typeData[0] at bit 0).
//   NBEAT = ceil(RULE_BITS/CFG_WIDTH). Defaults: 176 bits, 6 beats; last beat [31:16] ignored.
// - FSM states:
//   IDLE --WRITE--> LOAD (count NBEAT beats) --> COMMIT (1 cycle) --> IDLE
//   IDLE --INVAL--> COMMIT (valid=0, payload 0) --> IDLE
//   IDLE --CLEAR_ALL--> SWEEP (RULE_NUM cycles, idx 0..RULE_NUM-1, valid=0) --> IDLE
// - o_cfg_ready: 1 in IDLE and LOAD; 0 in COMMIT and SWEEP.
// - Latency:
//   - WRITE: wren asserts the cycle after the last payload beat.
//   - INVAL: wren asserts the cycle after the header beat.
//   - o_done pulses with the final wren (for CLEAR_ALL, with the idx RULE_NUM-1 wren).
// - Outputs are registered; payload is stable while wren is high. wren is exactly one-hot, or 0.
// - Commit sanitises typeData = typeData & typeMask, so a rule is never unmatchable.
// - o_rule_valid_map[idx] updates in the same cycle as wren[idx]:
//   WRITE sets it, INVAL and SWEEP clear it.
// - Bad opcode (0, 4..15): o_err pulses the cycle after the header; stay in IDLE; no wren.
// - WRITE with index >= RULE_NUM:
//   - all NBEAT payload beats are still consumed, keeping the stream aligned;
//   - no wren is issued;
//   - o_err pulses instead of o_done.
// - INVAL with index >= RULE_NUM: o_err pulses; no wren.
// - Bubbles (valid low) in LOAD: wait indefinitely; the beat counter holds.
// - Reset mid-LOAD or mid-SWEEP:
//   - partial record and sweep index are discarded immediately;
//   - no wren is issued after reset;
//   - valid map returns to 0, matching the table's reset.
// STRUCTURE
// - Package parser_cfg_pkg:
//   - opcode enum cfg_op_e (CFG_WRITE=1, CFG_INVAL=2, CFG_CLEAR=3);
//   - state enum;
//   - packed rule record struct type_rule_t;
//   - localparams RULE_BITS and NBEAT.
// - Sub-module rule_beat_packer: shift-assembles CFG_WIDTH beats into type_rule_t and flags the last beat.
// - Top level holds the FSM, index/sweep counter, output registers and valid map.
// TESTING
// - WRITE idx 3 with 6 beats (typeData[0]=0x0800, mask[0]=0xFFFF, offsets 1..8)
//   -> wren=0x08 one cycle after beat 6, o_done=1, valid_map=0x08.
// - WRITE idx 2 with data[0]=0x86DD, mask[0]=0xFF00
//   -> o_typeRule_typeData[15:0]=0x8600 at commit.
// - INVAL idx 3 after the previous case -> wren=0x08, valid=0, valid_map=0x00, ready low one cycle.
// - CLEAR_ALL -> wren walks 0x01..0x80 over 8 consecutive cycles, o_done on 0x80, ready low throughout.
// - WRITE idx 9 -> 6 beats accepted, no wren, o_err=1.
//   A following WRITE idx 0 -> wren=0x01 (stream stays aligned).
// - Assert i_rst after beat 3 of a WRITE -> no wren ever, ready=1 after reset, next full WRITE commits correctly.

Source files
------------

// File: rtl/type_rule_cfg_ctrl_pkg.sv
// rtl/type_rule_cfg_ctrl_pkg.sv - shared types and sizes for the type-rule config sequencer
package parser_cfg_pkg;

   localparam int RULE_NUM         = 8;
   localparam int TYPE_NUM         = 4;
   localparam int TYPE_WIDTH       = 16;
   localparam int KEY_FILED_NUM    = 8;
   localparam int KEY_OFFSET_WIDTH = 6;
   localparam int CFG_WIDTH        = 32;

   localparam int RULE_BITS  = KEY_FILED_NUM*KEY_OFFSET_WIDTH + 2*TYPE_NUM*TYPE_WIDTH;
   localparam int NBEAT      = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
   localparam int IDX_W      = $clog2(RULE_NUM);
   localparam int BEAT_CNT_W = $clog2(NBEAT);

   typedef enum logic [3:0] {
      CFG_WRITE = 4'd1,
      CFG_INVAL = 4'd2,
      CFG_CLEAR = 4'd3
   } cfg_op_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_SWEEP  = 2'd3;

   // First member lands in the MSBs, so typeData[0] sits at bit 0 of the record.
   typedef struct packed {
      logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_offset;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_mask;
      logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_data;
   } type_rule_t;

   function automatic logic [RULE_NUM-1:0] rule_onehot(input logic [IDX_W-1:0] idx);
      return RULE_NUM'(1) << idx;
   endfunction

endpackage

// File: rtl/type_rule_cfg_ctrl_if.sv
// rtl/type_rule_cfg_ctrl_if.sv - host config stream in, rule-table write port out
interface type_rule_cfg_ctrl_if;
   import parser_cfg_pkg::*;

   logic                                      i_cfg_valid;
   logic [CFG_WIDTH-1:0]                      i_cfg_data;
   logic                                      o_cfg_ready;
   logic [RULE_NUM-1:0]                       o_rule_wren;
   logic                                      o_typeRule_valid;
   logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeData;
   logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeMask;
   logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset;
   logic [RULE_NUM-1:0]                       o_rule_valid_map;
   logic                                      o_busy;
   logic                                      o_done;
   logic                                      o_err;

   modport master (
      output i_cfg_valid, i_cfg_data,
      input  o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
             o_typeRule_typeMask, o_typeRule_keyOffset, o_rule_valid_map,
             o_busy, o_done, o_err
   );

   modport slave (
      input  i_cfg_valid, i_cfg_data,
      output o_cfg_ready, o_rule_wren, o_typeRule_valid, o_typeRule_typeData,
             o_typeRule_typeMask, o_typeRule_keyOffset, o_rule_valid_map,
             o_busy, o_done, o_err
   );

endinterface

// File: rtl/type_rule_cfg_ctrl_packer.sv
// rtl/type_rule_cfg_ctrl_packer.sv - shifts payload beats into a rule record
// rule_o combines the beat being accepted with earlier beats, so it is complete on the last beat.
module rule_beat_packer
   import parser_cfg_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 beat_valid_i,
   input  logic [CFG_WIDTH-1:0] beat_data_i,
   output logic                 beat_last_o,
   output type_rule_t           rule_o
);

   localparam int PREV_W = (NBEAT-1)*CFG_WIDTH;
   localparam int FULL_W = NBEAT*CFG_WIDTH;

   logic [PREV_W-1:0]     prev_q, prev_d;
   logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
   logic [FULL_W-1:0]     full;

   assign full        = {beat_data_i, prev_q};
   assign rule_o      = type_rule_t'(full[RULE_BITS-1:0]);
   assign beat_last_o = beat_valid_i && (cnt_q == BEAT_CNT_W'(NBEAT-1));

   always_comb begin
      prev_d = prev_q;
      cnt_d  = cnt_q;
      if (beat_valid_i) begin
         prev_d = full[FULL_W-1:CFG_WIDTH];
         cnt_d  = beat_last_o ? '0 : cnt_q + BEAT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= '0;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/type_rule_cfg_ctrl.sv
// rtl/type_rule_cfg_ctrl.sv - config sequencer writing the parser type-lookup rule table
// Decodes header beats, assembles WRITE payloads, and issues one-hot table writes and sweeps.
module type_rule_cfg_ctrl
   import parser_cfg_pkg::*;
(
   input logic                 i_clk,
   input logic                 i_rst,
   type_rule_cfg_ctrl_if.slave cfg
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RULE_NUM-1);

   logic [1:0]                                state_q, state_d;
   logic [IDX_W-1:0]                          idx_q, idx_d;
   logic                                      idx_bad_q, idx_bad_d;
   logic [IDX_W-1:0]                          sweep_q, sweep_d;
   logic                                      ready_q, ready_d;
   logic [RULE_NUM-1:0]                       wren_q, wren_d;
   logic                                      valid_q, valid_d;
   logic [TYPE_NUM*TYPE_WIDTH-1:0]            data_q, data_d;
   logic [TYPE_NUM*TYPE_WIDTH-1:0]            mask_q, mask_d;
   logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] koff_q, koff_d;
   logic [RULE_NUM-1:0]                       map_q, map_d;
   logic                                      done_q, done_d;
   logic                                      err_q, err_d;

   logic             accept;
   logic [3:0]       hdr_op;
   logic [15:0]      hdr_idx;
   logic             hdr_bad;
   logic [IDX_W-1:0] hdr_sel;
   logic             pk_valid;
   logic             pk_last;
   type_rule_t       pk_rule;

   assign accept   = cfg.i_cfg_valid & ready_q;
   assign hdr_op   = cfg.i_cfg_data[CFG_WIDTH-1 -: 4];
   assign hdr_idx  = cfg.i_cfg_data[15:0];
   assign hdr_bad  = hdr_idx >= 16'(RULE_NUM);
   assign hdr_sel  = hdr_idx[IDX_W-1:0];
   assign pk_valid = accept && (state_q == ST_LOAD);

   rule_beat_packer u_packer (
      .clk_i        (i_clk),
      .rst_i        (i_rst),
      .beat_valid_i (pk_valid),
      .beat_data_i  (cfg.i_cfg_data),
      .beat_last_o  (pk_last),
      .rule_o       (pk_rule)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      idx_bad_d = idx_bad_q;
      sweep_d   = sweep_q;
      wren_d    = '0;
      valid_d   = valid_q;
      data_d    = data_q;
      mask_d    = mask_q;
      koff_d    = koff_q;
      map_d     = map_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (hdr_op)
                  CFG_WRITE: begin
                     state_d   = ST_LOAD;
                     idx_d     = hdr_sel;
                     idx_bad_d = hdr_bad;
                  end
                  CFG_INVAL: begin
                     if (hdr_bad) begin
                        err_d = 1'b1;
                     end else begin
                        state_d        = ST_COMMIT;
                        wren_d         = rule_onehot(hdr_sel);
                        valid_d        = 1'b0;
                        data_d         = '0;
                        mask_d         = '0;
                        koff_d         = '0;
                        map_d[hdr_sel] = 1'b0;
                        done_d         = 1'b1;
                     end
                  end
                  CFG_CLEAR: begin
                     state_d  = ST_SWEEP;
                     sweep_d  = '0;
                     wren_d   = rule_onehot('0);
                     valid_d  = 1'b0;
                     data_d   = '0;
                     mask_d   = '0;
                     koff_d   = '0;
                     map_d[0] = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_LOAD: begin
            // Out-of-range writes still drain every payload beat to keep the stream aligned.
            if (pk_last) begin
               if (idx_bad_q) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d      = ST_COMMIT;
                  wren_d       = rule_onehot(idx_q);
                  valid_d      = 1'b1;
                  data_d       = pk_rule.type_data & pk_rule.type_mask;
                  mask_d       = pk_rule.type_mask;
                  koff_d       = pk_rule.key_offset;
                  map_d[idx_q] = 1'b1;
                  done_d       = 1'b1;
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         ST_SWEEP: begin
            if (sweep_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               sweep_d        = sweep_q + IDX_W'(1);
               wren_d         = rule_onehot(sweep_d);
               map_d[sweep_d] = 1'b0;
               done_d         = (sweep_d == LAST_IDX);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         idx_bad_q <= 1'b0;
         sweep_q   <= '0;
         ready_q   <= 1'b0;
         wren_q    <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         mask_q    <= '0;
         koff_q    <= '0;
         map_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         idx_bad_q <= idx_bad_d;
         sweep_q   <= sweep_d;
         ready_q   <= ready_d;
         wren_q    <= wren_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         mask_q    <= mask_d;
         koff_q    <= koff_d;
         map_q     <= map_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cfg.o_cfg_ready          = ready_q;
   assign cfg.o_rule_wren          = wren_q;
   assign cfg.o_typeRule_valid     = valid_q;
   assign cfg.o_typeRule_typeData  = data_q;
   assign cfg.o_typeRule_typeMask  = mask_q;
   assign cfg.o_typeRule_keyOffset = koff_q;
   assign cfg.o_rule_valid_map     = map_q;
   assign cfg.o_busy               = (state_q != ST_IDLE);
   assign cfg.o_done               = done_q;
   assign cfg.o_err                = err_q;

endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
// tb/tb_type_rule_cfg_ctrl.sv - directed scoreboard bench for type_rule_cfg_ctrl
module tb_type_rule_cfg_ctrl;
   import parser_cfg_pkg::*;

   typedef struct {
      int           cyc;
      logic [7:0]   wren;
      logic         valid;
      logic [175:0] pl;
      logic         chk_pl;
      logic         done;
      logic         err;
      logic [7:0]   map;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   logic [7:0] exp_map = '0;

   type_rule_cfg_ctrl_if cfg();

   type_rule_cfg_ctrl dut (
      .i_clk (clk),
      .i_rst (rst),
      .cfg   (cfg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input int c, input logic [7:0] w, input logic v, input logic [175:0] pl,
                          input logic cp, input logic d, input logic e);
      ev_t ev;
      ev.cyc = c; ev.wren = w; ev.valid = v; ev.pl = pl;
      ev.chk_pl = cp; ev.done = d; ev.err = e; ev.map = exp_map;
      exp_q.push_back(ev);
   endtask

   // Every DUT pulse must match the oldest queued expectation, including its cycle.
   always @(negedge clk) begin
      if (cfg.o_rule_wren != 0 || cfg.o_done || cfg.o_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {cfg.o_rule_wren, cfg.o_done, cfg.o_err}, 0);
         end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            chk("ev_cycle", cyc, ev.cyc);
            chk("ev_wren", cfg.o_rule_wren, ev.wren);
            chk("ev_done_err", {cfg.o_done, cfg.o_err}, {ev.done, ev.err});
            chk("ev_map", cfg.o_rule_valid_map, ev.map);
            chk("ev_ready", cfg.o_cfg_ready, ev.wren == 0);
            chk("ev_busy", cfg.o_busy, ev.wren != 0);
            if (ev.chk_pl) begin
               chk("ev_valid", cfg.o_typeRule_valid, ev.valid);
               chk("ev_payload", {cfg.o_typeRule_keyOffset, cfg.o_typeRule_typeMask,
                                  cfg.o_typeRule_typeData}, ev.pl);
            end
         end
      end
   end

   // Leaves valid high at the negedge before the accepting posedge; stamp is when results show.
   task automatic send_beat(input logic [31:0] d, input int gap, output int stamp);
      int t;
      cfg.i_cfg_valid = 1'b0;
      repeat (gap) @(negedge clk);
      cfg.i_cfg_valid = 1'b1;
      cfg.i_cfg_data  = d;
      t = 0;
      while (!cfg.o_cfg_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_assert++;
      assert (t < 50) else begin
         n_fail++;
         $error("FAIL ready_wait observed=%0d cycles expected=<50", t);
      end
      stamp = cyc + 1;
   endtask

   task automatic finish_beat();
      @(negedge clk);
      cfg.i_cfg_valid = 1'b0;
   endtask

   function automatic logic [175:0] make_rec(input logic [63:0] d, input logic [63:0] m,
                                             input int koff_base);
      logic [47:0] k;
      for (int i = 0; i < 8; i++) k[i*6 +: 6] = 6'(koff_base + i);
      return {k, m, d};
   endfunction

   function automatic logic [175:0] sanitize(input logic [175:0] r);
      return {r[175:64], r[63:0] & r[127:64]};
   endfunction

   task automatic write_rule(input logic [15:0] idx, input logic [175:0] rec, input int gap);
      logic [191:0] full;
      int s;
      full = {16'hDEAD, rec};
      send_beat({4'h1, 12'h000, idx}, 0, s);
      finish_beat();
      chk("load_busy", cfg.o_busy, 1);
      for (int i = 0; i < NBEAT; i++) begin
         send_beat(full[i*32 +: 32], gap, s);
         if (i == NBEAT-1) begin
            if (idx < 16'd8) begin
               exp_map[idx[2:0]] = 1'b1;
               push_ev(s, 8'(1) << idx[2:0], 1'b1, sanitize(rec), 1'b1, 1'b1, 1'b0);
            end else begin
               push_ev(s, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            end
         end
         finish_beat();
      end
   endtask

   task automatic send_hdr_ev(input logic [31:0] h, input logic [7:0] w, input logic d, input logic e);
      int s;
      send_beat(h, 0, s);
      push_ev(s, w, 1'b0, '0, w != 0, d, e);
      finish_beat();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [175:0] r;
      logic [31:0] part;
      rst = 1'b1;
      cfg.i_cfg_valid = 1'b0;
      cfg.i_cfg_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", cfg.o_cfg_ready, 0);
      chk("rst_outputs", {cfg.o_rule_wren, cfg.o_rule_valid_map, cfg.o_busy, cfg.o_done,
                          cfg.o_err, cfg.o_typeRule_valid}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", cfg.o_cfg_ready, 1);

      write_rule(16'd3, make_rec({16'h0001, 16'h0002, 16'h0003, 16'h0800},
                                 {16'h00FF, 16'hFFFF, 16'h0F0F, 16'hFFFF}, 1), 0);
      write_rule(16'd2, make_rec({16'h1234, 16'hAAAA, 16'h5555, 16'h86DD},
                                 {16'hF0F0, 16'h0FF0, 16'hFFFF, 16'hFF00}, 10), 2);

      exp_map[3] = 1'b0;
      send_hdr_ev(32'h2000_0003, 8'h08, 1'b1, 1'b0);
      @(negedge clk);
      chk("inval_ready_back", cfg.o_cfg_ready, 1);

      send_hdr_ev(32'h5000_0001, 8'h00, 1'b0, 1'b1);
      send_hdr_ev(32'h0000_0002, 8'h00, 1'b0, 1'b1);
      send_hdr_ev(32'h2000_000C, 8'h00, 1'b0, 1'b1);

      write_rule(16'd7, make_rec(64'hFFFF_0000_1111_2222, 64'h0F0F_F0F0_FFFF_0000, 20), 1);

      send_beat(32'h3000_0000, 0, s);
      for (int i = 0; i < 8; i++) begin
         exp_map[i] = 1'b0;
         push_ev(s + i, 8'(1) << i, 1'b0, '0, 1'b1, i == 7, 1'b0);
      end
      finish_beat();

      write_rule(16'd9, make_rec(64'h1, 64'h1, 3), 0);
      write_rule(16'd0, make_rec(64'hCAFE_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 30), 0);

      r = make_rec(64'h0BAD_0BAD_0BAD_0BAD, 64'hFFFF_0000_FFFF_0000, 40);
      send_beat(32'h1000_0004, 0, s);
      finish_beat();
      for (int i = 0; i < 3; i++) begin
         part = r[i*32 +: 32];
         send_beat(part, 0, s);
         finish_beat();
      end
      rst = 1'b1;
      exp_map = '0;
      repeat (2) @(negedge clk);
      chk("midrst_ready", cfg.o_cfg_ready, 0);
      chk("midrst_map", cfg.o_rule_valid_map, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_back", cfg.o_cfg_ready, 1);
      chk("midrst_idle", {cfg.o_busy, cfg.o_rule_valid_map}, 0);
      repeat (10) @(negedge clk);

      write_rule(16'd6, make_rec(64'h8100_0800_86DD_0806, 64'hFFFF_FF00_FFFF_00FF, 5), 1);

      repeat (5) @(negedge clk);
      chk("final_map", cfg.o_rule_valid_map, exp_map);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
